// File: rtl/dsp_chain_drain_pkg.sv
// Shared definitions for the DSP chain drain: chain width, default accumulator
// width, accumulator state encoding and the packed result record.
package dsp_chain_pkg;

  localparam int CHAIN_W       = 37;
  localparam int ACC_W_DEFAULT = 48;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  // Result record at the default width; the FIFO stores the same {ovf, data} layout.
  typedef struct packed {
    logic                     ovf;
    logic [ACC_W_DEFAULT-1:0] data;
  } res_t;

endpackage

// File: rtl/dsp_chain_drain_if.sv
// Handshake bundle between the DSP chain, the drain and the result consumer.
// master = environment side (chain + writeback), slave = the drain itself.
interface dsp_chain_drain_if #(
  parameter int CHAIN_W = dsp_chain_pkg::CHAIN_W,
  parameter int ACC_W   = dsp_chain_pkg::ACC_W_DEFAULT,
  parameter int DEPTH   = 4
);

  logic [CHAIN_W-1:0]       chain_in;
  logic                     chain_valid;
  logic                     chain_last;
  logic                     chain_ready;
  logic [ACC_W-1:0]         res_data;
  logic                     res_ovf;
  logic                     res_valid;
  logic                     res_ready;
  logic [$clog2(DEPTH):0]   fill_level;
  logic                     clr_err;
  logic                     err_drop;

  modport master (
    output chain_in, chain_valid, chain_last, res_ready, clr_err,
    input  chain_ready, res_data, res_ovf, res_valid, fill_level, err_drop
  );

  modport slave (
    input  chain_in, chain_valid, chain_last, res_ready, clr_err,
    output chain_ready, res_data, res_ovf, res_valid, fill_level, err_drop
  );

endinterface

// File: rtl/dsp_chain_drain_res_fifo.sv
// Small synchronous result FIFO; occupancy is tracked by a separate count so
// pointers can simply wrap.
module dsp_chain_res_fifo #(
  parameter int W     = 49,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign dout  = mem[rd_ptr];

  // Storage, pointers and count; a simultaneous push and pop leaves count alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en && !rd_en) begin
        count <= count + 1'b1;
      end else if (rd_en && !wr_en) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/dsp_chain_drain.sv
// Drains the last DSP chain stage: accumulates partial sums per dot product and
// queues each finished result, with its carry-out flag, for the writeback.
module dsp_chain_drain #(
  parameter int CHAIN_W = dsp_chain_pkg::CHAIN_W,
  parameter int ACC_W   = dsp_chain_pkg::ACC_W_DEFAULT,
  parameter int DEPTH   = 4
) (
  input logic               clk,
  input logic               reset,
  dsp_chain_drain_if.slave  bus
);

  import dsp_chain_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic             acc_ovf;
  logic             err_drop_q;

  logic             chain_ready_i;
  logic             accept;
  logic             drop;
  logic             push;
  logic             pop;
  logic             in_accum;
  logic [ACC_W:0]   base;
  logic [ACC_W:0]   chain_zext;
  logic [ACC_W:0]   sum;
  logic             ovf_next;

  logic [CW-1:0]    count;
  logic             empty;
  logic [ACC_W:0]   fifo_dout;

  // The chain cannot stall, so ready only reflects free FIFO space.
  assign chain_ready_i = (count != CW'(DEPTH));
  assign accept        = bus.chain_valid && chain_ready_i;
  assign drop          = bus.chain_valid && !chain_ready_i;
  assign push          = accept && bus.chain_last;
  assign pop           = !empty && bus.res_ready;

  assign in_accum   = (state == ACCUM);
  assign base       = in_accum ? {1'b0, acc} : '0;
  assign chain_zext = {{(ACC_W + 1 - CHAIN_W){1'b0}}, bus.chain_in};
  assign sum        = base + chain_zext;
  assign ovf_next   = (in_accum && acc_ovf) || sum[ACC_W];

  // Accumulator FSM plus the sticky drop flag; a drop beats a clear in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      acc        <= '0;
      acc_ovf    <= 1'b0;
      err_drop_q <= 1'b0;
    end else begin
      if (drop) begin
        err_drop_q <= 1'b1;
      end else if (bus.clr_err) begin
        err_drop_q <= 1'b0;
      end
      if (accept) begin
        if (bus.chain_last) begin
          state   <= IDLE;
          acc     <= '0;
          acc_ovf <= 1'b0;
        end else begin
          state   <= ACCUM;
          acc     <= sum[ACC_W-1:0];
          acc_ovf <= ovf_next;
        end
      end
    end
  end

  dsp_chain_res_fifo #(
    .W     (ACC_W + 1),
    .DEPTH (DEPTH)
  ) u_res_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   ({ovf_next, sum[ACC_W-1:0]}),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (count),
    .empty (empty)
  );

  assign bus.chain_ready = chain_ready_i;
  assign bus.res_data    = fifo_dout[ACC_W-1:0];
  assign bus.res_ovf     = fifo_dout[ACC_W];
  assign bus.res_valid   = !empty;
  assign bus.fill_level  = count;
  assign bus.err_drop    = err_drop_q;

endmodule

// File: tb/tb_dsp_chain_drain.sv
// Bench for dsp_chain_drain: directed vector table, a narrow-accumulator overflow
// case, then randomized traffic compared against a dot-product/queue model.
module tb_dsp_chain_drain;

  import dsp_chain_pkg::*;

  localparam int ACC_W       = 48;
  localparam int ACC_W_SMALL = 38;
  localparam int DEPTH       = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  dsp_chain_drain_if #(.ACC_W(ACC_W), .DEPTH(DEPTH))       bus   ();
  dsp_chain_drain_if #(.ACC_W(ACC_W_SMALL), .DEPTH(DEPTH)) bus38 ();

  dsp_chain_drain #(.ACC_W(ACC_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  dsp_chain_drain #(.ACC_W(ACC_W_SMALL), .DEPTH(DEPTH)) dut38 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus38.slave)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: running dot-product total and a queue of finished results.
  res_t        mQ[$];
  logic [63:0] mTotal;
  bit          mErr;

  typedef struct {
    string       name;
    bit          v;
    bit          l;
    logic [36:0] d;
    bit          rdy;
    bit          clr;
    bit          eValid;
    logic [47:0] eData;
    int          eFill;
    bit          eReady;
    bit          eErr;
  } vec_t;

  vec_t vecs[$];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mQ.delete();
    mTotal = '0;
    mErr   = 1'b0;
  endtask

  // Drive one cycle of inputs at a falling edge, let the rising edge pass, update the model.
  task automatic applyStimulus(input bit v, input bit l, input logic [36:0] d,
                               input bit rdy, input bit clr);
    bit   rdyM;
    bit   popM;
    res_t r;
    bus.chain_valid = v;
    bus.chain_last  = l;
    bus.chain_in    = d;
    bus.res_ready   = rdy;
    bus.clr_err     = clr;
    @(negedge clk);
    rdyM = (mQ.size() != DEPTH);
    popM = (mQ.size() != 0) && rdy;
    if (v && !rdyM) mErr = 1'b1;
    else if (clr)   mErr = 1'b0;
    if (popM) void'(mQ.pop_front());
    if (v && rdyM) begin
      mTotal = mTotal + 64'(d);
      if (l) begin
        r.ovf  = (mTotal >= (64'd1 << ACC_W));
        r.data = mTotal[ACC_W-1:0];
        mQ.push_back(r);
        mTotal = '0;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    cmp($sformatf("%s res_valid", tag),   64'(bus.res_valid),   64'(mQ.size() != 0));
    cmp($sformatf("%s fill_level", tag),  64'(bus.fill_level),  64'(mQ.size()));
    cmp($sformatf("%s chain_ready", tag), 64'(bus.chain_ready), 64'(mQ.size() != DEPTH));
    cmp($sformatf("%s err_drop", tag),    64'(bus.err_drop),    64'(mErr));
    if (mQ.size() != 0) begin
      cmp($sformatf("%s res_data", tag), 64'(bus.res_data), 64'(mQ[0].data));
      cmp($sformatf("%s res_ovf", tag),  64'(bus.res_ovf),  64'(mQ[0].ovf));
    end
  endtask

  task automatic addVec(input string n, input bit v, input bit l, input logic [36:0] d,
                        input bit rdy, input bit clr, input bit ev, input logic [47:0] ed,
                        input int ef, input bit er, input bit ee);
    vec_t x;
    x.name = n;  x.v = v;  x.l = l;  x.d = d;  x.rdy = rdy;  x.clr = clr;
    x.eValid = ev;  x.eData = ed;  x.eFill = ef;  x.eReady = er;  x.eErr = ee;
    vecs.push_back(x);
  endtask

  initial begin
    logic [63:0] rnd;
    bus.chain_valid   = 1'b0;
    bus.chain_last    = 1'b0;
    bus.chain_in      = '0;
    bus.res_ready     = 1'b0;
    bus.clr_err       = 1'b0;
    bus38.chain_valid = 1'b0;
    bus38.chain_last  = 1'b0;
    bus38.chain_in    = '0;
    bus38.res_ready   = 1'b0;
    bus38.clr_err     = 1'b0;
    modelReset();

    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("initial");

    // Some traffic, then a 3-cycle reset in the middle of a dot product.
    applyStimulus(1, 1, 37'd55, 0, 0);
    applyStimulus(1, 0, 37'd100, 0, 0);
    bus.chain_valid = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    modelReset();
    @(negedge clk);
    cmp("reset res_valid",   64'(bus.res_valid),   64'd0);
    cmp("reset fill_level",  64'(bus.fill_level),  64'd0);
    cmp("reset chain_ready", 64'(bus.chain_ready), 64'd1);
    cmp("reset err_drop",    64'(bus.err_drop),    64'd0);
    cmp("reset res_data",    64'(bus.res_data),    64'd0);

    //      name          v  l  d                 rdy clr ev ed                  fill rdy err
    addVec("A beat100",   1, 0, 37'd100,          0,  0,  0, 48'd0,              0,   1,  0);
    addVec("A beat200",   1, 0, 37'd200,          0,  0,  0, 48'd0,              0,   1,  0);
    addVec("A last300",   1, 1, 37'd300,          0,  0,  1, 48'd600,            1,   1,  0);
    addVec("A pop",       0, 0, 37'd0,            1,  0,  0, 48'd0,              0,   1,  0);
    addVec("B single",    1, 1, 37'h1F_FFFF_FFFF, 0,  0,  1, 48'h1F_FFFF_FFFF,   1,   1,  0);
    addVec("B pop",       0, 0, 37'd0,            1,  0,  0, 48'd0,              0,   1,  0);
    addVec("C push1",     1, 1, 37'd1,            0,  0,  1, 48'd1,              1,   1,  0);
    addVec("C push2",     1, 1, 37'd2,            0,  0,  1, 48'd1,              2,   1,  0);
    addVec("C push3",     1, 1, 37'd3,            0,  0,  1, 48'd1,              3,   1,  0);
    addVec("C push4",     1, 1, 37'd4,            0,  0,  1, 48'd1,              4,   0,  0);
    addVec("C drop5",     1, 1, 37'd5,            0,  0,  1, 48'd1,              4,   0,  1);
    addVec("C pop1",      0, 0, 37'd0,            1,  0,  1, 48'd2,              3,   1,  1);
    addVec("C pop2",      0, 0, 37'd0,            1,  0,  1, 48'd3,              2,   1,  1);
    addVec("C pop3",      0, 0, 37'd0,            1,  0,  1, 48'd4,              1,   1,  1);
    addVec("C pop4",      0, 0, 37'd0,            1,  0,  0, 48'd0,              0,   1,  1);
    addVec("D clr",       0, 0, 37'd0,            0,  1,  0, 48'd0,              0,   1,  0);
    addVec("E push7",     1, 1, 37'd7,            0,  0,  1, 48'd7,              1,   1,  0);
    addVec("E push8",     1, 1, 37'd8,            0,  0,  1, 48'd7,              2,   1,  0);
    addVec("E push9pop",  1, 1, 37'd9,            1,  0,  1, 48'd8,              2,   1,  0);
    addVec("E pop8",      0, 0, 37'd0,            1,  0,  1, 48'd9,              1,   1,  0);
    addVec("E pop9",      0, 0, 37'd0,            1,  0,  0, 48'd0,              0,   1,  0);
    addVec("F push10",    1, 1, 37'd10,           0,  0,  1, 48'd10,             1,   1,  0);
    addVec("F push11",    1, 1, 37'd11,           0,  0,  1, 48'd10,             2,   1,  0);
    addVec("F push12",    1, 1, 37'd12,           0,  0,  1, 48'd10,             3,   1,  0);
    addVec("F push13",    1, 1, 37'd13,           0,  0,  1, 48'd10,             4,   0,  0);
    addVec("F drop14",    1, 1, 37'd14,           0,  0,  1, 48'd10,             4,   0,  1);
    addVec("F dropclr",   1, 1, 37'd15,           0,  1,  1, 48'd10,             4,   0,  1);
    addVec("F clr",       0, 0, 37'd0,            0,  1,  1, 48'd10,             4,   0,  0);
    addVec("F fullpop",   1, 1, 37'd16,           1,  0,  1, 48'd11,             3,   1,  1);
    addVec("F clr2",      0, 0, 37'd0,            0,  1,  1, 48'd11,             3,   1,  0);
    addVec("F pop11",     0, 0, 37'd0,            1,  0,  1, 48'd12,             2,   1,  0);
    addVec("F pop12",     0, 0, 37'd0,            1,  0,  1, 48'd13,             1,   1,  0);
    addVec("F pop13",     0, 0, 37'd0,            1,  0,  0, 48'd0,              0,   1,  0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].v, vecs[i].l, vecs[i].d, vecs[i].rdy, vecs[i].clr);
      cmp($sformatf("%s valid", vecs[i].name), 64'(bus.res_valid),   64'(vecs[i].eValid));
      cmp($sformatf("%s fill", vecs[i].name),  64'(bus.fill_level),  64'(vecs[i].eFill));
      cmp($sformatf("%s ready", vecs[i].name), 64'(bus.chain_ready), 64'(vecs[i].eReady));
      cmp($sformatf("%s err", vecs[i].name),   64'(bus.err_drop),    64'(vecs[i].eErr));
      if (vecs[i].eValid) begin
        cmp($sformatf("%s data", vecs[i].name), 64'(bus.res_data), 64'(vecs[i].eData));
        cmp($sformatf("%s ovf", vecs[i].name),  64'(bus.res_ovf),  64'd0);
      end
      checkOutput(vecs[i].name);
    end

    // Narrow accumulator: three max-width partials carry out of 38 bits.
    for (int i = 0; i < 3; i++) begin
      bus38.chain_valid = 1'b1;
      bus38.chain_last  = (i == 2);
      bus38.chain_in    = 37'h1F_FFFF_FFFF;
      applyStimulus(0, 0, 37'd0, 0, 0);
    end
    bus38.chain_valid = 1'b0;
    bus38.chain_last  = 1'b0;
    cmp("acc38 res_valid",  64'(bus38.res_valid),  64'd1);
    cmp("acc38 res_data",   64'(bus38.res_data),   64'h1F_FFFF_FFFD);
    cmp("acc38 res_ovf",    64'(bus38.res_ovf),    64'd1);
    cmp("acc38 fill_level", 64'(bus38.fill_level), 64'd1);

    // Randomized traffic: a slow consumer first so the FIFO fills and drops occur.
    for (int i = 0; i < 600; i++) begin
      rnd = {$urandom(), $urandom()};
      applyStimulus($urandom_range(0, 3) != 0,
                    $urandom_range(0, 2) == 0,
                    rnd[36:0],
                    (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1),
                    $urandom_range(0, 15) == 0);
      checkOutput($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dsp_chain_drain.md
Name: dsp_chain_drain

Overview:
- Tail-end consumer of a cascaded int_sop_2 DSP chain.
- Takes the 37-bit chainout of the last chain stage as a stream of partial sums and accumulates the partials belonging to one dot product.
- Pushes each finished dot product, with an overflow flag, into a small result FIFO drained by a valid/ready consumer.
- Sits between the DSP chain and the layer's output writeback.

Parameters:
- CHAIN_W, 37, width of chain partial sum (matches chain stage output).
- ACC_W, 48, accumulator / result width; must be > CHAIN_W.
- DEPTH, 4, result FIFO entries; power of 2, >= 2.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- chain_in  in  CHAIN_W  partial sum from last chain stage, unsigned.
- chain_valid  in  1  chain_in valid this cycle.
- chain_last  in  1  qualifies chain_valid; beat is the final partial of the current dot product.
- chain_ready  out  1  drain can accept a beat this cycle.
- res_data  out  ACC_W  head-of-FIFO dot-product result.
- res_ovf  out  1  head result overflowed ACC_W.
- res_valid  out  1  FIFO non-empty.
- res_ready  in  1  consumer accepts head this cycle.
- fill_level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- clr_err  in  1  synchronous clear of err_drop.
- err_drop  out  1  sticky: a beat arrived while chain_ready=0.

Behaviour:
- Reset (reset=0, asynchronous): acc=0, acc_ovf=0, state=IDLE, FIFO pointers and count=0, all FIFO entries 0, err_drop=0. Hence res_valid=0, res_data=0, res_ovf=0, fill_level=0, chain_ready=1.
- chain_ready = (count != DEPTH). It is combinational from the registered count. The chain cannot stall, so upstream must honour it with its own slack.
- Beat accepted when chain_valid && chain_ready. chain_last is ignored when chain_valid=0.
- Arithmetic: chain_in is zero-extended to ACC_W+1 bits. sum = base + zext(chain_in), where base is 0 in IDLE and acc in ACCUM. ovf_next = (base_ovf | sum[ACC_W]), where base_ovf is 0 in IDLE and acc_ovf in ACCUM. Result is wrap-around modulo 2^ACC_W with the carry recorded, not saturated.
- State machine, two states:
  - IDLE, accepted beat with !chain_last: acc <= sum[ACC_W-1:0], acc_ovf <= ovf_next, go to ACCUM.
  - IDLE, accepted beat with chain_last: single-beat dot product. Push {ovf_next, sum} and stay in IDLE.
  - ACCUM, accepted beat with !chain_last: accumulate as above.
  - ACCUM, accepted beat with chain_last: push {ovf_next, sum}, acc <= 0, acc_ovf <= 0, go to IDLE.
  - No accepted beat: hold state.
- Latency: last beat accepted in cycle N, so res_valid=1 and res_data is valid in cycle N+1 when the FIFO was empty. There is no bypass path.
- Pop when res_valid && res_ready. res_data and res_ovf are driven from the head entry. After the final pop, res_data shows the stale entry; consumers must qualify with res_valid.
- Simultaneous push and pop:
  - Allowed when count < DEPTH; count unchanged, both pointers advance.
  - When full, chain_ready=0 so no push occurs and the pop frees one slot. chain_ready returns to 1 in the next cycle.
- Pointer wrap: read/write pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty is decided by the separate count register.
- Dropped beat (chain_valid && !chain_ready): beat discarded, acc and state untouched, err_drop <= 1.
  - err_drop clears only on reset or clr_err=1.
  - If clr_err=1 and a drop occur in the same cycle, set wins (err_drop=1).
- Reset mid-dot-product: partial accumulation and all FIFO contents are lost. After reset the next beat starts a new dot product.

Decomposition:
- Shared package dsp_chain_pkg holds:
  - CHAIN_W = 37, shared with the chain stage.
  - Default ACC_W.
  - State enum {IDLE, ACCUM}.
  - Packed result struct {ovf, data}.
- One sub-module, dsp_chain_res_fifo: parameterised sync FIFO (push/pop/count, async active-low reset) storing the ACC_W+1-bit packed result. Accumulator and FSM stay in the top module.

Test Plan:
- Reset: hold reset=0 for 3 cycles mid-traffic, release → res_valid=0, fill_level=0, chain_ready=1, err_drop=0 in the first cycle after release.
- Beats 100, 200, 300 (last on 300) on consecutive cycles → cycle after last: res_valid=1, res_data=600, res_ovf=0, fill_level=1.
- Single beat 37'h1F_FFFF_FFFF with chain_last → res_data=37'h1F_FFFF_FFFF. Then, with ACC_W overridden to 38, beats 2^37-1 twice + last beat 2^37-1 → res_ovf=1, res_data=(3·(2^37-1)) mod 2^38.
- res_ready=0, push 4 one-beat results (1, 2, 3, 4) → fill_level=4, chain_ready=0. A further beat 5 with chain_valid → err_drop=1, FIFO still holds 1, 2, 3, 4. Then res_ready=1 → pops 1, 2, 3, 4 in order, chain_ready=1 after the first pop.
- FIFO at 2, push (last beat 9) and pop in the same cycle → fill_level stays 2, and 9 emerges after the two prior entries.
- err_drop=1, assert clr_err with no drop → err_drop=0 next cycle. clr_err together with a dropped beat → err_drop stays 1.
